// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: address and instruction widths, the canonical
// NOP encoding, and the fetch front-end FSM state type.
package riscv_pkg;

   localparam int unsigned XLEN      = 64;
   localparam int unsigned INSTR_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_RUN   = 2'd1,
      FETCH_FAULT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} entries.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   flush                 empties the FIFO; overrides push and pop that cycle
//   push, push_data       write an entry (ignored when full without a pop)
//   pop                   drop the head entry (ignored when empty)
//   head_data             head entry; holds the last presented entry while empty
//   empty, count          occupancy status
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = XLEN + INSTR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] hold_q;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty   = (cnt == '0);
   assign count   = cnt;
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && ((cnt != FULL_CNT) || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Remember whatever the head last showed so the outputs stay put while empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)      hold_q <= '0;
      else if (!empty) hold_q <= mem[rd_ptr];
   end

   assign head_data = empty ? hold_q : mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch front-end: issues sequential word reads to a registered-read
// memory, tags each returned word with its PC in a prefetch FIFO, and hands the
// FIFO head to decode over valid/ready. Execute may redirect the stream.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (misaligned redirect -> sticky
// fetch_fault and FAULT state; otherwise redirect_pc[1:0] is ignored).
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   fetch_en                       allow new requests
//   mem_addr, mem_rstrb, mem_rdata memory read request / next-cycle data
//   instr_valid/ready/data/pc      decode handshake and FIFO head
//   redirect_valid, redirect_pc    flush and restart fetch
//   fetch_fault                    sticky misaligned-redirect flag
module fetch_prefetch
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = riscv_pkg::XLEN,
   parameter int unsigned     DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   output logic [XLEN-1:0]   mem_addr,
   output logic              mem_rstrb,
   input  logic [31:0]       mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr_data,
   output logic [XLEN-1:0]   instr_pc,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              fetch_fault
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

   fetch_state_e               state_q;
   fetch_state_e               state_d;
   logic [XLEN-1:0]            fetch_pc_q;
   logic [XLEN-1:0]            inflight_pc_q;
   logic                       inflight_q;
   logic [CW-1:0]              fifo_count;
   logic                       fifo_empty;
   logic [XLEN+INSTR_W-1:0]    fifo_head;
   logic                       credit_ok;
   logic                       issue;
   logic                       resp_kill;
   logic                       resp_push;
   logic                       misalign;
   logic [XLEN-1:0]            redirect_aligned;

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef FETCH_MISALIGN_CHECK_EN
   assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   logic unused_redirect_lsb;
   assign misalign            = 1'b0;
   assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

   // Entries held plus the one response still in flight must fit in the FIFO,
   // so a landing response always has a free slot.
   assign credit_ok = (fifo_count + CW'(inflight_q)) < DEPTH_CNT;

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      unique case (state_q)
         FETCH_IDLE: begin
            if (fetch_en) state_d = FETCH_RUN;
         end
         FETCH_RUN: begin
            issue = fetch_en && credit_ok && !redirect_valid;
            if (!fetch_en) state_d = FETCH_IDLE;
         end
         FETCH_FAULT: begin
            state_d = FETCH_FAULT;
         end
         default: state_d = FETCH_IDLE;
      endcase
      // A redirect returns to RUN directly when fetch is enabled so the first
      // request to the new PC goes out in the very next cycle.
      if (redirect_valid) begin
         if (misalign)                   state_d = FETCH_FAULT;
         else if (state_q == FETCH_FAULT) state_d = FETCH_RUN;
         else if (fetch_en)              state_d = FETCH_RUN;
         else                            state_d = FETCH_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= FETCH_IDLE;
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (issue) inflight_pc_q <= fetch_pc_q;
         if (redirect_valid)  fetch_pc_q <= redirect_aligned;
         else if (issue)      fetch_pc_q <= fetch_pc_q + XLEN'(4);
      end
   end

   // Issue is suppressed during a redirect, so the only response that can be
   // in flight across a redirect is the one landing in that same cycle.
   assign resp_kill = inflight_q && redirect_valid;
   assign resp_push = inflight_q && !resp_kill;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              fault_q <= 1'b0;
      else if (redirect_valid) fault_q <= misalign;
   end
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN + INSTR_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (resp_push),
      .push_data ({inflight_pc_q, mem_rdata}),
      .pop       (instr_valid && instr_ready),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign mem_addr    = fetch_pc_q;
   assign mem_rstrb   = issue;
   assign instr_valid = !fifo_empty;
   assign instr_data  = fifo_head[INSTR_W-1:0];
   assign instr_pc    = fifo_head[XLEN+INSTR_W-1:INSTR_W];

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_en = 1'b0;
   logic [63:0] mem_addr;
   logic        mem_rstrb;
   logic [31:0] mem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_data;
   logic [63:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        fetch_fault;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   fetch_prefetch #(
      .XLEN     (64),
      .DEPTH    (4),
      .RESET_PC (64'h0)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_en       (fetch_en),
      .mem_addr       (mem_addr),
      .mem_rstrb      (mem_rstrb),
      .mem_rdata      (mem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   // Memory image: word at address A is 0x13 | (A/4 << 7), i.e. 0x13, 0x93, 0x113, 0x193, ...
   always @(posedge clk) begin
      if (mem_rstrb) mem_rdata <= 32'h13 | {mem_addr[26:2], 7'b0};
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [63:0] pc, input logic [31:0] data);
      exp_q.push_back('{pc: pc, data: data});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      fetch_en = 1'b0;
      redirect_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   // Scoreboard monitor: every accepted instruction must match the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (reset && instr_valid && instr_ready && !redirect_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_instr: got pc %h data %h expected none", instr_pc, instr_data);
         end else begin
            e = exp_q.pop_front();
            check("instr_pc", instr_pc, e.pc);
            check("instr_data", 64'(instr_data), 64'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Reset state
      instr_ready = 1'b1;
      repeat (2) @(posedge clk);
      smp();
      check("rst_instr_valid", 64'(instr_valid), 64'h0);
      check("rst_mem_rstrb", 64'(mem_rstrb), 64'h0);
      check("rst_mem_addr", mem_addr, 64'h0);
      check("rst_instr_pc", instr_pc, 64'h0);
      check("rst_instr_data", 64'(instr_data), 64'h0);
      check("rst_fetch_fault", 64'(fetch_fault), 64'h0);

      // 1: streaming, latency request N -> valid N+2
      cyc();
      reset = 1'b1;
      fetch_en = 1'b1;
      push_exp(64'h0, 32'h13);
      push_exp(64'h4, 32'h93);
      push_exp(64'h8, 32'h113);
      push_exp(64'hC, 32'h193);
      smp(); check("t1_c0_rstrb", 64'(mem_rstrb), 64'h0);
      cyc();
      smp(); check("t1_c1_rstrb", 64'(mem_rstrb), 64'h1);
             check("t1_c1_addr", mem_addr, 64'h0);
      cyc();
      smp(); check("t1_c2_addr", mem_addr, 64'h4);
             check("t1_c2_valid", 64'(instr_valid), 64'h0);
      cyc();
      smp(); check("t1_c3_addr", mem_addr, 64'h8);
             check("t1_c3_valid", 64'(instr_valid), 64'h1);
      cyc();
      smp(); check("t1_c4_addr", mem_addr, 64'hC);
      cyc();
      fetch_en = 1'b0;
      smp(); check("t1_c5_rstrb", 64'(mem_rstrb), 64'h0);
      repeat (4) cyc();

      // 2: decode stalled, credit limits to DEPTH requests
      do_reset();
      instr_ready = 1'b0;
      fetch_en = 1'b1;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         smp();
         if (mem_rstrb) begin
            check("t2_req_addr", mem_addr, 64'(n * 4));
            n++;
         end
         if (i == 9) begin
            check("t2_rstrb_low", 64'(mem_rstrb), 64'h0);
            check("t2_head_pc", instr_pc, 64'h0);
         end
         cyc();
      end
      check("t2_req_count", 64'(n), 64'd4);
      push_exp(64'h0, 32'h13);
      push_exp(64'h4, 32'h93);
      push_exp(64'h8, 32'h113);
      push_exp(64'hC, 32'h193);
      instr_ready = 1'b1;
      fetch_en = 1'b0;
      repeat (6) cyc();

      // 3/4: redirect while 0x8 response lands, with pop and push pending
      do_reset();
      instr_ready = 1'b1;
      fetch_en = 1'b1;
      push_exp(64'h0, 32'h13);
      push_exp(64'h40, 32'h813);
      push_exp(64'h44, 32'h893);
      cyc();
      smp(); check("t3_req0", mem_addr, 64'h0);
      cyc();
      smp(); check("t3_req4", mem_addr, 64'h4);
      cyc();
      smp(); check("t3_req8_rstrb", 64'(mem_rstrb), 64'h1);
             check("t3_req8_addr", mem_addr, 64'h8);
      cyc();
      redirect_valid = 1'b1;
      redirect_pc = 64'h40;
      smp(); check("t3_redir_rstrb", 64'(mem_rstrb), 64'h0);
             check("t4_head_before_flush", instr_pc, 64'h4);
      cyc();
      redirect_valid = 1'b0;
      smp(); check("t3_empty_after", 64'(instr_valid), 64'h0);
             check("t3_new_rstrb", 64'(mem_rstrb), 64'h1);
             check("t3_new_addr", mem_addr, 64'h40);
      cyc();
      smp(); check("t4_no_stale", 64'(instr_valid), 64'h0);
             check("t3_next_addr", mem_addr, 64'h44);
      cyc();
      fetch_en = 1'b0;
      smp(); check("t3_first_pc", instr_pc, 64'h40);
             check("t3_first_valid", 64'(instr_valid), 64'h1);
      repeat (4) cyc();

      // 5: reset with three entries buffered
      instr_ready = 1'b0;
      fetch_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         smp();
         if (i == 4) check("t5_valid_before", 64'(instr_valid), 64'h1);
         cyc();
      end
      reset = 1'b0;
      #1;
      check("t5_valid_in_reset", 64'(instr_valid), 64'h0);
      check("t5_rstrb_in_reset", 64'(mem_rstrb), 64'h0);
      check("t5_addr_in_reset", mem_addr, 64'h0);
      fetch_en = 1'b0;
      repeat (2) cyc();
      reset = 1'b1;
      fetch_en = 1'b1;
      instr_ready = 1'b1;
      push_exp(64'h0, 32'h13);
      smp(); check("t5_idle_rstrb", 64'(mem_rstrb), 64'h0);
      cyc();
      smp(); check("t5_restart_rstrb", 64'(mem_rstrb), 64'h1);
             check("t5_restart_addr", mem_addr, 64'h0);
      cyc();
      fetch_en = 1'b0;
      repeat (4) cyc();

      // 6: misaligned redirect
      fetch_en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'h42;
`ifdef FETCH_MISALIGN_CHECK_EN
      push_exp(64'h44, 32'h893);
      smp(); check("t6_redir_rstrb", 64'(mem_rstrb), 64'h0);
      cyc();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         check("t6_fault_set", 64'(fetch_fault), 64'h1);
         check("t6_no_issue", 64'(mem_rstrb), 64'h0);
         cyc();
      end
      redirect_valid = 1'b1;
      redirect_pc = 64'h44;
      smp(); check("t6_clear_cycle_rstrb", 64'(mem_rstrb), 64'h0);
      cyc();
      redirect_valid = 1'b0;
      smp(); check("t6_fault_clear", 64'(fetch_fault), 64'h0);
             check("t6_resume_rstrb", 64'(mem_rstrb), 64'h1);
             check("t6_resume_addr", mem_addr, 64'h44);
      cyc();
      fetch_en = 1'b0;
`else
      push_exp(64'h40, 32'h813);
      smp(); check("t6_redir_rstrb", 64'(mem_rstrb), 64'h0);
      cyc();
      redirect_valid = 1'b0;
      smp(); check("t6_fault_tied", 64'(fetch_fault), 64'h0);
             check("t6_aligned_rstrb", 64'(mem_rstrb), 64'h1);
             check("t6_aligned_addr", mem_addr, 64'h40);
      cyc();
      fetch_en = 1'b0;
`endif
      repeat (4) cyc();

      // 7: fetch_pc wraps at the top of the address space
      fetch_en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      push_exp(64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FF93);
      push_exp(64'h0, 32'h13);
      cyc();
      redirect_valid = 1'b0;
      smp(); check("t7_top_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc();
      smp(); check("t7_wrap_addr", mem_addr, 64'h0);
             check("t7_wrap_rstrb", 64'(mem_rstrb), 64'h1);
      cyc();
      fetch_en = 1'b0;

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
